// File: rtl/i2c_slave_rx_sequencer_if.sv
// Bus-side bundle of the I2C slave write sequencer: synchronized SCL/SDA in,
// ACK pull-down, byte-store write port and transaction status out.
interface i2c_slave_rx_sequencer_if #(
  parameter int NUM_BYTES = 6
);
  localparam int AW = $clog2(NUM_BYTES);

  logic          SCL;
  logic          SDA;
  logic          SDA_down;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   byte_count;
  logic          busy;
  logic          overflow;
  logic          done;

  // Sequencer side: samples the bus, drives the ACK and the write port.
  modport slave (
    input  SCL, SDA,
    output SDA_down, wr_en, wr_addr, wr_data, byte_count, busy, overflow, done
  );

  // Bus-master / byte-store side.
  modport master (
    output SCL, SDA,
    input  SDA_down, wr_en, wr_addr, wr_data, byte_count, busy, overflow, done
  );
endinterface

// File: rtl/i2c_slave_rx_sequencer.sv
// I2C slave write-path sequencer: START/STOP detection, address match,
// data-byte capture into a byte store and ACK/NACK generation.
// Reads (R/W bit = 1) and foreign addresses are NACKed and ignored.
module i2c_slave_rx_sequencer #(
  parameter int       NUM_BYTES  = 6,
  parameter bit [6:0] SLAVE_ADDR = 7'h42
) (
  input logic                      FPGA_clk,
  input logic                      rst_n,
  i2c_slave_rx_sequencer_if.slave  bus
);
  localparam int AW = $clog2(NUM_BYTES);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_A_ACK  = 3'd2,
    ST_DATA   = 3'd3,
    ST_D_ACK  = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          scl_q, sda_q;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] idx_q, idx_d;          // one bit wider so it never wraps
  logic [CW-1:0] byte_count_q, byte_count_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;
  logic          sda_down_q, sda_down_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          done_q, done_d;
  logic          match_q, match_d;      // address byte addressed us as a write
  logic          wrote_q, wrote_d;      // last data byte was stored (ACK it)
  logic          ack_phase_q, ack_phase_d; // first fall of ACK slot already seen

  logic rise_s, fall_s, start_s, stop_s;
  logic [7:0] shift_in_s;

  assign rise_s     = bus.SCL & ~scl_q;
  assign fall_s     = ~bus.SCL & scl_q;
  assign start_s    = bus.SCL & scl_q & sda_q & ~bus.SDA;
  assign stop_s     = bus.SCL & scl_q & ~sda_q & bus.SDA;
  assign shift_in_s = {shift_q[6:0], bus.SDA};

  // Next-state and output decode; START/STOP pre-empt every state.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    byte_count_d = byte_count_q;
    overflow_d   = overflow_q;
    busy_d       = busy_q;
    sda_down_d   = sda_down_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    match_d      = match_q;
    wrote_d      = wrote_q;
    ack_phase_d  = ack_phase_q;

    if (start_s) begin
      state_d      = ST_ADDR;
      bit_cnt_d    = 3'd0;
      idx_d        = {CW{1'b0}};
      byte_count_d = {CW{1'b0}};
      overflow_d   = 1'b0;
      busy_d       = 1'b0;
      sda_down_d   = 1'b0;
      ack_phase_d  = 1'b0;
    end else if (stop_s) begin
      done_d     = busy_q;
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      sda_down_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (rise_s) begin
            shift_d   = shift_in_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              match_d     = (shift_in_s[7:1] == SLAVE_ADDR) && (shift_in_s[0] == 1'b0);
              ack_phase_d = 1'b0;
              state_d     = ST_A_ACK;
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_A_ACK: begin
          if (fall_s && !ack_phase_q) begin
            sda_down_d  = match_q;
            busy_d      = match_q;
            ack_phase_d = 1'b1;
          end else if (fall_s) begin
            sda_down_d = 1'b0;
            bit_cnt_d  = 3'd0;
            state_d    = match_q ? ST_DATA : ST_IGNORE;
          end else begin
            state_d = ST_A_ACK;
          end
        end
        ST_DATA: begin
          if (rise_s) begin
            shift_d   = shift_in_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_phase_d = 1'b0;
              state_d     = ST_D_ACK;
              if (idx_q < CW'(NUM_BYTES)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q[AW-1:0];
                wr_data_d = shift_in_s;
                idx_d     = idx_q + CW'(1);
                wrote_d   = 1'b1;
                if (byte_count_q < CW'(NUM_BYTES)) begin
                  byte_count_d = byte_count_q + CW'(1);
                end else begin
                  byte_count_d = byte_count_q;
                end
              end else begin
                overflow_d = 1'b1;
                wrote_d    = 1'b0;
              end
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_D_ACK: begin
          if (fall_s && !ack_phase_q) begin
            sda_down_d  = wrote_q;
            ack_phase_d = 1'b1;
          end else if (fall_s) begin
            sda_down_d = 1'b0;
            bit_cnt_d  = 3'd0;
            state_d    = ST_DATA;
          end else begin
            state_d = ST_D_ACK;
          end
        end
        ST_IDLE:   state_d = ST_IDLE;
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; the bus history resets to an idle (high) bus.
  always_ff @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      idx_q        <= {CW{1'b0}};
      byte_count_q <= {CW{1'b0}};
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      sda_down_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {AW{1'b0}};
      wr_data_q    <= 8'h00;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      wrote_q      <= 1'b0;
      ack_phase_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_q        <= bus.SCL;
      sda_q        <= bus.SDA;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      byte_count_q <= byte_count_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      sda_down_q   <= sda_down_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      match_q      <= match_d;
      wrote_q      <= wrote_d;
      ack_phase_q  <= ack_phase_d;
    end
  end

  assign bus.SDA_down   = sda_down_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.byte_count = byte_count_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_i2c_slave_rx_sequencer.sv
// Directed bench for the I2C slave write sequencer: bit-banged SCL/SDA
// transactions, ACK sampling during the 9th clock, logged byte-store writes.
module tb_i2c_slave_rx_sequencer;
  localparam int NB = 6;
  localparam int Q  = 4;   // FPGA_clk cycles per quarter of an SCL bit

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  i2c_slave_rx_sequencer_if #(.NUM_BYTES(NB)) bus ();

  i2c_slave_rx_sequencer #(.NUM_BYTES(NB), .SLAVE_ADDR(7'h42)) dut (
    .FPGA_clk (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write-port pulse and every done pulse.
  logic [2:0] wa_log [0:31];
  logic [7:0] wd_log [0:31];
  int wr_cnt   = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_log[wr_cnt] <= bus.wr_addr;
      wd_log[wr_cnt] <= bus.wr_data;
      wr_cnt         <= wr_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.SDA = b;   wait_q(Q);
    bus.SCL = 1'b1; wait_q(2 * Q);
    bus.SCL = 1'b0; wait_q(Q);
  endtask

  // Ninth clock with SDA released; ack = SDA_down held across SCL high.
  task automatic ack_bit(output logic ack);
    logic a0, a1;
    bus.SDA = 1'b1; wait_q(Q);
    bus.SCL = 1'b1; wait_q(Q);
    a0 = bus.SDA_down; wait_q(Q);
    a1 = bus.SDA_down;
    bus.SCL = 1'b0; wait_q(Q);
    ack = a0 & a1;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(ack);
  endtask

  task automatic i2c_start();
    bus.SDA = 1'b1; wait_q(Q);
    bus.SCL = 1'b1; wait_q(Q);
    bus.SDA = 1'b0; wait_q(Q);
    bus.SCL = 1'b0; wait_q(Q);
  endtask

  task automatic i2c_stop();
    bus.SDA = 1'b0; wait_q(Q);
    bus.SCL = 1'b1; wait_q(Q);
    bus.SDA = 1'b1; wait_q(2 * Q);
  endtask

  initial begin
    logic ack;
    int   wbase, dbase;
    rst_n   = 1'b0;
    bus.SCL = 1'b1;
    bus.SDA = 1'b1;
    wait_q(3);

    // Reset state
    check("rst_sda_down", bus.SDA_down, 32'd0);
    check("rst_wr_en", bus.wr_en, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_overflow", bus.overflow, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_byte_count", bus.byte_count, 32'd0);
    rst_n = 1'b1;
    wait_q(4);

    // Addressed write of two bytes
    wbase = wr_cnt; dbase = done_cnt;
    i2c_start();
    send_byte(8'h84, ack); check("t1_addr_ack", ack, 32'd1);
    check("t1_busy", bus.busy, 32'd1);
    send_byte(8'hA5, ack); check("t1_d0_ack", ack, 32'd1);
    send_byte(8'h3C, ack); check("t1_d1_ack", ack, 32'd1);
    i2c_stop();
    check("t1_wr_cnt", wr_cnt - wbase, 32'd2);
    check("t1_wa0", wa_log[wbase], 32'd0);
    check("t1_wd0", wd_log[wbase], 32'hA5);
    check("t1_wa1", wa_log[wbase + 1], 32'd1);
    check("t1_wd1", wd_log[wbase + 1], 32'h3C);
    check("t1_byte_count", bus.byte_count, 32'd2);
    check("t1_done_cnt", done_cnt - dbase, 32'd1);
    check("t1_busy_after", bus.busy, 32'd0);

    // Foreign address 0x48
    wbase = wr_cnt; dbase = done_cnt;
    i2c_start();
    send_byte(8'h90, ack); check("t2_addr_nack", ack, 32'd0);
    send_byte(8'h11, ack); check("t2_data_nack", ack, 32'd0);
    i2c_stop();
    check("t2_wr_cnt", wr_cnt - wbase, 32'd0);
    check("t2_done_cnt", done_cnt - dbase, 32'd0);

    // Read request to our address
    wbase = wr_cnt; dbase = done_cnt;
    i2c_start();
    send_byte(8'h85, ack); check("t3_addr_nack", ack, 32'd0);
    check("t3_busy", bus.busy, 32'd0);
    send_byte(8'h55, ack); check("t3_data_nack", ack, 32'd0);
    i2c_stop();
    check("t3_wr_cnt", wr_cnt - wbase, 32'd0);
    check("t3_done_cnt", done_cnt - dbase, 32'd0);

    // Overflow: seven data bytes into a six-byte store
    wbase = wr_cnt; dbase = done_cnt;
    i2c_start();
    send_byte(8'h84, ack); check("t4_addr_ack", ack, 32'd1);
    for (int i = 1; i <= 7; i++) begin
      send_byte(8'(i), ack);
      check($sformatf("t4_d%0d_ack", i), ack, (i <= NB) ? 32'd1 : 32'd0);
    end
    check("t4_overflow", bus.overflow, 32'd1);
    check("t4_byte_count", bus.byte_count, 32'd6);
    i2c_stop();
    check("t4_wr_cnt", wr_cnt - wbase, 32'd6);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("t4_wa%0d", i), wa_log[wbase + i], 32'(i));
      check($sformatf("t4_wd%0d", i), wd_log[wbase + i], 32'(i + 1));
    end
    check("t4_done_cnt", done_cnt - dbase, 32'd1);
    check("t4_overflow_sticky", bus.overflow, 32'd1);
    i2c_start();
    check("t4_overflow_clr", bus.overflow, 32'd0);
    check("t4_byte_count_clr", bus.byte_count, 32'd0);
    i2c_stop();

    // Repeated START between two writes
    wbase = wr_cnt; dbase = done_cnt;
    i2c_start();
    send_byte(8'h84, ack); check("t5_addr0_ack", ack, 32'd1);
    send_byte(8'hAA, ack); check("t5_d0_ack", ack, 32'd1);
    i2c_start();
    check("t5_busy_rs", bus.busy, 32'd0);
    send_byte(8'h84, ack); check("t5_addr1_ack", ack, 32'd1);
    send_byte(8'hBB, ack); check("t5_d1_ack", ack, 32'd1);
    i2c_stop();
    check("t5_wr_cnt", wr_cnt - wbase, 32'd2);
    check("t5_wa0", wa_log[wbase], 32'd0);
    check("t5_wd0", wd_log[wbase], 32'hAA);
    check("t5_wa1", wa_log[wbase + 1], 32'd0);
    check("t5_wd1", wd_log[wbase + 1], 32'hBB);
    check("t5_done_cnt", done_cnt - dbase, 32'd1);

    // Reset during the ACK of the first data byte
    i2c_start();
    send_byte(8'h84, ack); check("t6_addr_ack", ack, 32'd1);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h5A >> i));
    bus.SDA = 1'b1; wait_q(Q);
    bus.SCL = 1'b1; wait_q(2);
    check("t6_ack_pre_rst", bus.SDA_down, 32'd1);
    #3 rst_n = 1'b0;
    #1 check("t6_ack_async_rel", bus.SDA_down, 32'd0);
    check("t6_busy_rst", bus.busy, 32'd0);
    wait_q(2);
    rst_n = 1'b1;
    wait_q(Q);
    bus.SCL = 1'b0; wait_q(Q);
    wbase = wr_cnt; dbase = done_cnt;
    send_byte(8'h84, ack); check("t6_noaddr_nack", ack, 32'd0);
    send_byte(8'h77, ack); check("t6_nodata_nack", ack, 32'd0);
    check("t6_no_wr", wr_cnt - wbase, 32'd0);
    check("t6_busy_idle", bus.busy, 32'd0);
    i2c_start();
    send_byte(8'h84, ack); check("t6_addr2_ack", ack, 32'd1);
    send_byte(8'h77, ack); check("t6_d_ack", ack, 32'd1);
    i2c_stop();
    check("t6_wr_cnt", wr_cnt - wbase, 32'd1);
    check("t6_wa0", wa_log[wbase], 32'd0);
    check("t6_wd0", wd_log[wbase], 32'h77);
    check("t6_done_cnt", done_cnt - dbase, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/i2c_slave_rx_sequencer.md
Name: i2c_slave_rx_sequencer

Overview:
Transaction-level controller for the I2C slave write path. It detects START/STOP, shifts in and matches the 7-bit address byte, and sequences data-byte capture into the slave's byte store through a simple write port. It also drives the ACK/NACK pull-down. It sits between the synchronized SCL/SDA pins and the slave register/byte RAM. Read transactions are out of scope and are NACKed.

Parameters:
NUM_BYTES, 6, depth of the downstream byte store; maximum data bytes accepted per transaction
SLAVE_ADDR, 7'h42, 7-bit address this slave responds to

Ports:
FPGA_clk  in  1  system clock; oversamples SCL/SDA by at least 8x
rst_n  in  1  asynchronous active-low reset
SCL  in  1  bus clock, already synchronized to FPGA_clk
SDA  in  1  bus data, already synchronized to FPGA_clk
SDA_down  out  1  1 = pull SDA low (ACK); 0 = release
wr_en  out  1  one-cycle pulse: write wr_data to wr_addr
wr_addr  out  $clog2(NUM_BYTES)  byte index within the transaction
wr_data  out  8  received byte, MSB first on the bus
byte_count  out  $clog2(NUM_BYTES)+1  bytes written in the current or last transaction
busy  out  1  1 from matched address until STOP or START
overflow  out  1  sticky: more than NUM_BYTES data bytes were offered; cleared at next START
done  out  1  one-cycle pulse on STOP ending an addressed write

Behaviour:
- Reset (async assert, sync deassert effect): state=IDLE. All outputs 0. SDA_down releases immediately on rst_n low. Internal SCL_q and SDA_q are set to 1 (idle bus).
- Edge detection: SCL_q/SDA_q register the inputs each cycle.
  - rise = SCL & ~SCL_q; fall = ~SCL & SCL_q.
  - START = SCL & SCL_q & SDA_q & ~SDA.
  - STOP = SCL & SCL_q & ~SDA_q & SDA.
  - SCL and SDA changing in the same cycle is never START/STOP.
  - Each detected event takes effect at the same FPGA_clk edge; outputs reflect it 1 cycle after the input change was first sampled.
- START/STOP have priority over all other events, in every state.
  - START (including repeated START): go to ADDR. Clear bit counter, byte index, byte_count, overflow, busy. Release SDA_down.
  - STOP: if busy, pulse done. Go to IDLE, busy=0, SDA_down=0.
- States:
  - IDLE: wait for START.
  - ADDR: on each rise, shift SDA into an 8-bit shift register. When the 8th bit is sampled, evaluate: match = (shift[7:1]==SLAVE_ADDR) & (shift[0]==0).
  - A_ACK: on the first fall after the 8th bit, SDA_down=1 if match. On the next fall, SDA_down=0, then go to DATA if match, else go to IGNORE. busy=1 from the SDA_down assertion onward.
  - DATA: shift 8 bits on rise. On the 8th bit:
    - if byte index < NUM_BYTES: next cycle wr_en=1 for exactly 1 cycle, wr_addr=index, wr_data=byte; byte_count increments and the index increments.
    - else: no write; overflow=1.
    - Then go to D_ACK.
  - D_ACK: on the first fall, SDA_down=1 only if the byte was written (NACK on overflow). On the next fall, SDA_down=0 and go to DATA.
  - IGNORE: stay, with no outputs, until START/STOP.
- Index does not wrap. byte_count saturates at NUM_BYTES.
- SDA changing while SCL is high mid-byte is always START/STOP, never data.
- wr_addr and wr_data hold their last values between pulses.

Test Plan:
- Write 0x84, 0xA5, 0x3C, STOP → 3 ACKs (SDA_down high across each 9th SCL high); wr_en pulses (addr 0, data A5) and (addr 1, data 3C); byte_count=2; one done pulse; busy=0 after STOP.
- Address byte 0x90 (addr 0x48) then 0x11 → SDA_down never asserted; no wr_en; done stays 0 at STOP.
- Address byte 0x85 (read to 0x42) → NACK; state IGNORE; no wr_en; no done.
- NUM_BYTES=6: write 0x84 then 7 bytes 0x01..0x07 → six writes (addr 0..5); 7th byte NACKed; overflow=1; byte_count=6; done at STOP; next START clears overflow.
- 0x84, 0xAA, then repeated START, 0x84, 0xBB, STOP → writes (0, AA) then (0, BB); exactly one done pulse.
- Drop rst_n during the ACK of byte 1 → SDA_down=0 with no clock edge; after release the block ignores bus traffic until the next START.
